// File: rtl/usrt_apb_pkg.sv
// usrt_apb_pkg
// Shared definitions for the USRT APB requester:
//   - apb_state_e     : requester FSM state encoding
//   - USRT_*_ADDR     : USRT register map offsets
//   - DEFAULT_TIMEOUT : default ACCESS-phase wait limit (cycles)
//   - DEFAULT_CNT_W   : default width of the timeout counter
package usrt_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic [31:0] USRT_DATA_ADDR = 32'h0000_0000;
    localparam logic [31:0] USRT_CTRL_ADDR = 32'h0000_0004;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt
// Clear/enable up-counter that flags when it has reached TIMEOUT-1.
// Ports:
//   clk      : clock
//   rst_n    : asynchronous active-low reset (clears the count)
//   clear    : synchronous clear, wins over enable
//   enable   : increment by one this cycle
//   terminal : count currently equals TIMEOUT-1
module apb_timeout_cnt #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminal = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/usrt_apb_master.sv
// usrt_apb_master
// APB requester for the USRT slave interface. Takes one read/write command
// from the host, runs APB SETUP then ACCESS (waiting for pReady, bounded by
// TIMEOUT cycles), and presents the result on the response port.
// Ports:
//   pClk, pReset                  : clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata : host command channel
//   rsp_valid/ready/rdata/err/timeout: host response channel
//   pSelect/pEnable/pWrite/pAddr/pWData : APB requester outputs
//   pRData/pReady/pSlverr         : APB completer returns
module usrt_apb_master
    import usrt_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              pSelect,
    output logic              pEnable,
    output logic              pWrite,
    output logic [ADDR_W-1:0] pAddr,
    output logic [DATA_W-1:0] pWData,
    input  logic [DATA_W-1:0] pRData,
    input  logic              pReady,
    input  logic              pSlverr
);

    apb_state_e        state_q,     state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              rsp_to_q,    rsp_to_d;

    logic cnt_clear;
    logic cnt_en;
    logic cnt_tc;

    // Counts ACCESS cycles without pReady; terminal means this is the last
    // cycle we are willing to wait.
    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk      (pClk),
        .rst_n    (pReset),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .terminal (cnt_tc)
    );

    // Next-state and next-output logic. Every output is a flop so the APB
    // and host sides never see combinational paths from the other side.
    // cmd_ready comes up one edge after reset release.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    state_d     = SETUP;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pReady is checked first so a late completion on the
                // terminal cycle still returns real data.
                if (pReady) begin
                    rsp_rdata_d = pwrite_q ? '0 : pRData;
                    rsp_err_d   = pSlverr;
                    rsp_to_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else if (cnt_tc) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    cnt_clear   = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops PSEL/PENABLE immediately.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign pSelect     = psel_q;
    assign pEnable     = penable_q;
    assign pWrite      = pwrite_q;
    assign pAddr       = paddr_q;
    assign pWData      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_usrt_apb_master.sv
// tb_usrt_apb_master
// Bench for usrt_apb_master with TIMEOUT=4. Each transfer is described by
// its command, the number of slave wait states, the slave response and the
// host backpressure; expected cycle-by-cycle outputs follow from those.
module tb_usrt_apb_master;
    import usrt_apb_pkg::*;

    localparam int TMO = 4;

    logic        pClk;
    logic        pReset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        pSelect;
    logic        pEnable;
    logic        pWrite;
    logic [31:0] pAddr;
    logic [7:0]  pWData;
    logic [7:0]  pRData;
    logic        pReady;
    logic        pSlverr;

    usrt_apb_master #(
        .ADDR_W  (32),
        .DATA_W  (8),
        .TIMEOUT (TMO),
        .CNT_W   (8)
    ) dut (
        .pClk        (pClk),
        .pReset      (pReset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .pSelect     (pSelect),
        .pEnable     (pEnable),
        .pWrite      (pWrite),
        .pAddr       (pAddr),
        .pWData      (pWData),
        .pRData      (pRData),
        .pReady      (pReady),
        .pSlverr     (pSlverr)
    );

    // Free-running clock
    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit cmp_en = 0;

    // Expected outputs for the current cycle
    logic        exp_psel, exp_pen, exp_cmd_ready, exp_rsp_valid;
    logic        exp_pwrite;
    logic [31:0] exp_paddr;
    logic [7:0]  exp_pwdata;
    logic [7:0]  exp_rdata;
    logic        exp_err, exp_to;

    // Observations gathered while comparing
    int          psel_total = 0;
    int          pen_total  = 0;
    int          rsp_rise_cyc = 0;
    bit          prev_rv = 0;
    logic [7:0]  seen_rdata;
    logic        seen_err, seen_to;

    // Results of the most recent transfer
    int last_psel, last_pen, last_lat, last_span;

    // Hard stop in case something unexpected stalls the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare of every DUT output against the expectation
    task automatic compareCycle();
        checkOutput("pSelect",   32'(pSelect),   32'(exp_psel));
        checkOutput("pEnable",   32'(pEnable),   32'(exp_pen));
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_ready));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
        checkOutput("pWrite",    32'(pWrite),    32'(exp_pwrite));
        checkOutput("pAddr",     pAddr,          exp_paddr);
        checkOutput("pWData",    32'(pWData),    32'(exp_pwdata));
        if (exp_rsp_valid) begin
            checkOutput("rsp_rdata",   32'(rsp_rdata),   32'(exp_rdata));
            checkOutput("rsp_err",     32'(rsp_err),     32'(exp_err));
            checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
        end
        if (pSelect === 1'b1) psel_total++;
        if (pEnable === 1'b1) pen_total++;
        if (rsp_valid === 1'b1 && !prev_rv) rsp_rise_cyc = cyc;
        prev_rv = (rsp_valid === 1'b1);
        if (rsp_valid === 1'b1) begin
            seen_rdata = rsp_rdata;
            seen_err   = rsp_err;
            seen_to    = rsp_timeout;
        end
    endtask

    // Compare mid-cycle, then step to just after the next rising edge
    task automatic tick();
        @(negedge pClk);
        if (cmp_en) compareCycle();
        @(posedge pClk);
        #1;
        cyc++;
    endtask

    task automatic junkInputs();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_wdata = 8'($urandom);
        pReady    = 1'($urandom_range(0, 1));
        pSlverr   = 1'($urandom_range(0, 1));
        pRData    = 8'($urandom);
    endtask

    task automatic setIdleExp();
        exp_psel      = 1'b0;
        exp_pen       = 1'b0;
        exp_rsp_valid = 1'b0;
        exp_cmd_ready = 1'b1;
    endtask

    // One complete transfer. waits = ACCESS cycles with pReady low before
    // the completion; waits >= TMO means the slave never answers in time.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [7:0] wd,
                                 input int waits, input bit serr, input logic [7:0] rd,
                                 input int bp, input int gap, input bit junk_err);
        int  a_cycles;
        bit  tmo;
        int  psel0, pen0, cmd_cyc;

        setIdleExp();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        pReady    = 1'b0;
        repeat (gap) tick();

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        psel0     = psel_total;
        pen0      = pen_total;
        cmd_cyc   = cyc;
        tick();

        // SETUP
        exp_psel      = 1'b1;
        exp_cmd_ready = 1'b0;
        exp_pwrite    = wr;
        exp_paddr     = addr;
        exp_pwdata    = wd;
        junkInputs();
        tick();

        // ACCESS
        tmo      = (waits >= TMO);
        a_cycles = tmo ? TMO : waits + 1;
        exp_pen  = 1'b1;
        for (int i = 0; i < a_cycles; i++) begin
            junkInputs();
            pReady  = (i == waits);
            pSlverr = (i == waits) ? serr : (junk_err ? 1'b1 : 1'($urandom_range(0, 1)));
            pRData  = (i == waits) ? rd : 8'($urandom);
            tick();
        end

        // RESP
        exp_psel      = 1'b0;
        exp_pen       = 1'b0;
        exp_rsp_valid = 1'b1;
        exp_rdata     = (tmo || wr) ? 8'h00 : rd;
        exp_err       = tmo | serr;
        exp_to        = tmo;
        for (int j = 0; j <= bp; j++) begin
            junkInputs();
            rsp_ready = (j == bp);
            tick();
        end

        setIdleExp();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        pReady    = 1'b0;
        last_psel = psel_total - psel0;
        last_pen  = pen_total - pen0;
        last_lat  = rsp_rise_cyc - cmd_cyc;
        last_span = cyc - cmd_cyc;
    endtask

    initial begin
        int t0;
        pReset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        pRData    = '0;
        pReady    = 1'b0;
        pSlverr   = 1'b0;
        exp_pwrite = 1'b0;
        exp_paddr  = '0;
        exp_pwdata = '0;
        exp_rdata  = '0;
        exp_err    = 1'b0;
        exp_to     = 1'b0;

        // Reset: everything low, including cmd_ready
        #1 pReset = 1'b0;
        #1;
        checkOutput("reset_pSelect",   32'(pSelect),   0);
        checkOutput("reset_pEnable",   32'(pEnable),   0);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("reset_pAddr",     pAddr,          0);
        checkOutput("reset_pWData",    32'(pWData),    0);
        checkOutput("reset_pWrite",    32'(pWrite),    0);
        checkOutput("reset_rsp_err",   32'(rsp_err),   0);
        checkOutput("reset_rsp_rdata", 32'(rsp_rdata), 0);
        checkOutput("reset_rsp_to",    32'(rsp_timeout), 0);

        repeat (2) @(posedge pClk);
        #1;
        pReset = 1'b1;
        exp_psel = 1'b0; exp_pen = 1'b0; exp_rsp_valid = 1'b0; exp_cmd_ready = 1'b0;
        cmp_en = 1;
        tick();
        checkOutput("release_cmd_ready", 32'(cmd_ready), 1);

        // Zero-wait write
        $display("[TB] directed write");
        applyStimulus(1'b1, USRT_DATA_ADDR, 8'hA5, 0, 1'b0, 8'h77, 0, 0, 1'b0);
        checkOutput("wr_psel_cycles", 32'(last_psel), 2);
        checkOutput("wr_pen_cycles",  32'(last_pen),  1);
        checkOutput("wr_latency",     32'(last_lat),  3);
        checkOutput("wr_span",        32'(last_span), 4);
        checkOutput("wr_rdata",       32'(seen_rdata), 0);
        checkOutput("wr_err",         32'(seen_err),  0);

        // Read with three wait states
        $display("[TB] directed read with waits");
        applyStimulus(1'b0, USRT_CTRL_ADDR, 8'h11, 3, 1'b0, 8'h3C, 0, 1, 1'b0);
        checkOutput("rd_pen_cycles", 32'(last_pen),   4);
        checkOutput("rd_rdata",      32'(seen_rdata), 32'h3C);
        checkOutput("rd_err",        32'(seen_err),   0);

        // Slave error on completion, and pSlverr during waits ignored
        $display("[TB] directed slave error");
        applyStimulus(1'b0, USRT_DATA_ADDR, 8'h00, 0, 1'b1, 8'h5A, 0, 0, 1'b0);
        checkOutput("slverr_err", 32'(seen_err), 1);
        checkOutput("slverr_to",  32'(seen_to),  0);
        applyStimulus(1'b0, USRT_DATA_ADDR, 8'h00, 2, 1'b0, 8'h96, 0, 0, 1'b1);
        checkOutput("slverr_wait_err",   32'(seen_err),   0);
        checkOutput("slverr_wait_rdata", 32'(seen_rdata), 32'h96);

        // Timeout
        $display("[TB] directed timeout");
        applyStimulus(1'b0, USRT_CTRL_ADDR, 8'h00, 100, 1'b0, 8'hFF, 0, 0, 1'b0);
        checkOutput("tmo_pen_cycles", 32'(last_pen),   4);
        checkOutput("tmo_err",        32'(seen_err),   1);
        checkOutput("tmo_flag",       32'(seen_to),    1);
        checkOutput("tmo_rdata",      32'(seen_rdata), 0);

        // Completion on the last allowed cycle beats the timeout
        applyStimulus(1'b0, USRT_CTRL_ADDR, 8'h00, TMO - 1, 1'b0, 8'hC3, 0, 0, 1'b0);
        checkOutput("late_ready_to",    32'(seen_to),    0);
        checkOutput("late_ready_rdata", 32'(seen_rdata), 32'hC3);

        // Backpressure then back-to-back command
        $display("[TB] directed backpressure");
        t0 = cyc;
        applyStimulus(1'b1, USRT_DATA_ADDR, 8'h42, 0, 1'b0, 8'h00, 5, 0, 1'b0);
        applyStimulus(1'b1, USRT_CTRL_ADDR, 8'h24, 0, 1'b0, 8'h00, 0, 0, 1'b0);
        checkOutput("b2b_cycles", 32'(cyc - t0), 13);

        // Async reset in the middle of ACCESS
        $display("[TB] directed async reset");
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = USRT_CTRL_ADDR; cmd_wdata = 8'h00;
        tick();
        exp_psel = 1'b1; exp_cmd_ready = 1'b0;
        exp_pwrite = 1'b0; exp_paddr = USRT_CTRL_ADDR; exp_pwdata = 8'h00;
        cmd_valid = 1'b0;
        tick();
        exp_pen = 1'b1;
        pReady  = 1'b0;
        tick();
        cmp_en = 0;
        #2 pReset = 1'b0;
        #1;
        checkOutput("arst_pSelect",   32'(pSelect),   0);
        checkOutput("arst_pEnable",   32'(pEnable),   0);
        checkOutput("arst_rsp_valid", 32'(rsp_valid), 0);
        pReady = 1'b1;
        repeat (2) tick();
        checkOutput("arst_hold_rsp_valid", 32'(rsp_valid), 0);
        pReady = 1'b0;
        pReset = 1'b1;
        exp_psel = 1'b0; exp_pen = 1'b0; exp_rsp_valid = 1'b0; exp_cmd_ready = 1'b0;
        exp_pwrite = 1'b0; exp_paddr = '0; exp_pwdata = '0;
        cmp_en = 1;
        tick();
        checkOutput("arst_release_cmd_ready", 32'(cmd_ready), 1);
        applyStimulus(1'b1, USRT_DATA_ADDR, 8'h5C, 0, 1'b0, 8'h00, 0, 0, 1'b0);
        checkOutput("arst_after_latency", 32'(last_lat), 3);

        // Randomized transfers
        $display("[TB] random transfers");
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom
                : (($urandom_range(0, 1) == 1) ? USRT_CTRL_ADDR : USRT_DATA_ADDR);
            applyStimulus(1'($urandom_range(0, 1)), a, 8'($urandom),
                          $urandom_range(0, TMO + 1), 1'($urandom_range(0, 1)), 8'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
